// File: rtl/ps2_receptor.sv
// PS/2 device-to-host receiver.
// Synchronises the PS/2 lines, deglitches the PS/2 clock and deserialises
// 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
// Each frame ends in exactly one strobe: a byte, a parity error or a frame error.
module ps2_receptor #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clkps2,
    input  logic       dataps2,
    input  logic       rx_en,
    output logic [7:0] dato,
    output logic       dato_recibido,
    output logic       error_paridad,
    output logic       error_trama
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Abort fires one cycle early so the registered strobe lands TIMEOUT
    // cycles after the last filtered falling edge.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 2);

    localparam logic [1:0] ESPERA  = 2'd0;
    localparam logic [1:0] DATOS   = 2'd1;
    localparam logic [1:0] PARIDAD = 2'd2;
    localparam logic [1:0] PARADA  = 2'd3;

    logic                  clk_s1_q, clk_s2_q;
    logic                  dat_s1_q, dat_s2_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  fclk_q, fclk_d;
    logic                  fclk_prev_q;
    logic                  flanco_c;

    logic [1:0]            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_q, par_d;
    logic [CNT_W-1:0]      to_cnt_q, to_cnt_d;
    logic [7:0]            dato_q, dato_d;
    logic                  rec_q, rec_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;

    // Two-flop synchronisers, clock filter shift register and edge detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= '1;
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
        end else begin
            clk_s1_q    <= clkps2;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= dataps2;
            dat_s2_q    <= dat_s1_q;
            filt_q      <= {filt_q[FILTER_LEN-2:0], clk_s2_q};
            fclk_q      <= fclk_d;
            fclk_prev_q <= fclk_q;
        end
    end

    // Filtered clock only moves once the whole window agrees.
    always_comb begin
        fclk_d = fclk_q;
        if (&filt_q) begin
            fclk_d = 1'b1;
        end else if (~|filt_q) begin
            fclk_d = 1'b0;
        end
    end

    assign flanco_c = fclk_prev_q & ~fclk_q;

    // Frame FSM: next state, datapath and strobe decisions.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_cnt_d  = to_cnt_q;
        dato_d    = dato_q;
        rec_d     = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        if (!rx_en) begin
            state_d   = ESPERA;
            bit_cnt_d = 3'd0;
            to_cnt_d  = '0;
        end else if (state_q == ESPERA) begin
            to_cnt_d = '0;
            if (flanco_c && !dat_s2_q) begin
                state_d   = DATOS;
                bit_cnt_d = 3'd0;
            end
        end else if (flanco_c) begin
            to_cnt_d = '0;
            case (state_q)
                DATOS: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARIDAD;
                    end
                end
                PARIDAD: begin
                    par_d   = dat_s2_q;
                    state_d = PARADA;
                end
                default: begin
                    state_d = ESPERA;
                    if (!dat_s2_q) begin
                        ferr_d = 1'b1;
                    end else if (!(^{shift_q, par_q})) begin
                        perr_d = 1'b1;
                    end else begin
                        dato_d = shift_q;
                        rec_d  = 1'b1;
                    end
                end
            endcase
        end else if (to_cnt_q == TO_LAST) begin
            ferr_d    = 1'b1;
            state_d   = ESPERA;
            bit_cnt_d = 3'd0;
            to_cnt_d  = '0;
        end else begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
        end
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ESPERA;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            dato_q    <= 8'h00;
            rec_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
            dato_q    <= dato_d;
            rec_q     <= rec_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign dato          = dato_q;
    assign dato_recibido = rec_q;
    assign error_paridad = perr_q;
    assign error_trama   = ferr_q;

endmodule

// File: tb/tb_ps2_receptor.sv
// Scoreboard bench for ps2_receptor: directed scenarios plus random frames.
module tb_ps2_receptor;

    localparam int FL = 8;
    localparam int TO = 200;
    localparam int K_REC = 0;
    localparam int K_PAR = 1;
    localparam int K_TRM = 2;

    typedef struct {
        int          kind;
        logic [7:0]  b;
        longint      cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clkps2;
    logic       dataps2;
    logic       rx_en;
    logic [7:0] dato;
    logic       dato_recibido;
    logic       error_paridad;
    logic       error_trama;

    exp_t       sbq[$];
    int         compared   = 0;
    int         mismatched = 0;
    longint     cyc        = 0;
    logic [7:0] model_dato = 8'h00;
    bit         mon_en     = 1'b0;
    int         prev_n     = 0;

    ps2_receptor #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .clkps2        (clkps2),
        .dataps2       (dataps2),
        .rx_en         (rx_en),
        .dato          (dato),
        .dato_recibido (dato_recibido),
        .error_paridad (error_paridad),
        .error_trama   (error_trama)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint got, input longint want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference outcome of a frame from the protocol rules.
    function automatic int outcome(input logic [7:0] b, input logic par, input logic stop);
        if (!stop) return K_TRM;
        if (((^b) ^ par) == 1'b1) return K_REC;
        return K_PAR;
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive frame bits [from..to]; expected strobe appears one cycle after the
    // filtered stop edge: 2 sync + FL filter + 1 edge detect + 1 register.
    task automatic send_bits(input logic [7:0] b, input logic par, input logic stop,
                             input int h, input int from, input int to,
                             input bit expect_resp, output longint t_last);
        logic [10:0] fr;
        exp_t        e;
        fr = {stop, par, b, 1'b0};
        t_last = 0;
        for (int i = from; i <= to; i++) begin
            dataps2 = fr[i];
            wait_neg(h);
            clkps2 = 1'b0;
            t_last = cyc;
            if (i == 10 && expect_resp) begin
                e.kind = outcome(b, par, stop);
                e.b    = b;
                e.cyc  = cyc + FL + 4;
                sbq.push_back(e);
            end
            wait_neg(h);
            clkps2 = 1'b1;
        end
        dataps2 = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int h);
        longint t;
        send_bits(b, par, stop, h, 0, 10, 1'b1, t);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes.
    always @(negedge clk) begin
        int   n;
        int   kind;
        exp_t e;
        if (mon_en) begin
            n = int'(dato_recibido) + int'(error_paridad) + int'(error_trama);
            kind = dato_recibido ? K_REC : (error_paridad ? K_PAR : K_TRM);
            if (n > 1) chk("strobe_exclusive", n, 1);
            if (n != 0 && prev_n != 0) chk("strobe_width", prev_n, 0);
            if (n != 0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_strobe", kind + 16, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("strobe_kind", kind, e.kind);
                    chk("strobe_cycle", cyc, e.cyc);
                    if (e.kind == K_REC) model_dato = e.b;
                    chk("dato_on_strobe", dato, model_dato);
                end
            end else begin
                chk("dato_stable", dato, model_dato);
            end
            prev_n = n;
        end else begin
            prev_n = 0;
        end
    end

    initial begin
        longint t;
        exp_t   e;
        logic [7:0] b;
        logic   par;
        logic   stop;
        int     r;

        reset   = 1'b0;
        clkps2  = 1'b1;
        dataps2 = 1'b1;
        rx_en   = 1'b1;

        // 1: reset with idle lines.
        wait_neg(5);
        chk("reset_dato", dato, 8'h00);
        chk("reset_strobes", {dato_recibido, error_paridad, error_trama}, 3'b000);
        reset = 1'b1;
        mon_en = 1'b1;
        wait_neg(1000);

        // 2: ACK byte.
        send_frame(8'hFA, 1'b1, 1'b1, 20);
        wait_neg(40);
        chk("ack_dato", dato, 8'hFA);

        // 3: parity error keeps previous byte.
        send_frame(8'h08, 1'b1, 1'b1, 20);
        wait_neg(40);
        chk("parerr_dato_kept", dato, 8'hFA);

        // 4: back-to-back movement packet.
        send_frame(8'h09, ~(^8'h09), 1'b1, 20);
        send_frame(8'h05, ~(^8'h05), 1'b1, 20);
        send_frame(8'hFD, ~(^8'hFD), 1'b1, 20);
        wait_neg(40);
        chk("packet_last", dato, 8'hFD);

        // 5: frame stops after 4 data bits -> timeout, then a good frame.
        send_bits(8'hC3, 1'b1, 1'b1, 20, 0, 4, 1'b0, t);
        e.kind = K_TRM;
        e.b    = 8'h00;
        e.cyc  = t + 3 + FL + TO;
        sbq.push_back(e);
        wait_neg(TO + 100);
        chk("timeout_drained", sbq.size(), 0);
        send_frame(8'h3C, ~(^8'h3C), 1'b1, 20);
        wait_neg(40);
        chk("after_timeout", dato, 8'h3C);

        // 6: short clock glitches with data low must not start a frame.
        dataps2 = 1'b0;
        for (int g = 0; g < 6; g++) begin
            clkps2 = 1'b0;
            wait_neg(3);
            clkps2 = 1'b1;
            wait_neg(30);
        end
        dataps2 = 1'b1;
        wait_neg(TO + 50);
        // rx_en dropped mid-frame: the frame is discarded silently.
        send_bits(8'h55, ~(^8'h55), 1'b1, 20, 0, 4, 1'b0, t);
        rx_en = 1'b0;
        send_bits(8'h55, ~(^8'h55), 1'b1, 20, 5, 10, 1'b0, t);
        wait_neg(TO + 50);
        rx_en = 1'b1;
        chk("rx_en_dato_kept", dato, 8'h3C);

        // Random frames: good, bad parity, bad stop; random gaps or back-to-back.
        for (int k = 0; k < 24; k++) begin
            b    = 8'($urandom);
            r    = int'($urandom_range(0, 9));
            par  = (r < 2) ? (^b) : ~(^b);
            stop = (r == 2) ? 1'b0 : 1'b1;
            send_frame(b, par, stop, int'($urandom_range(16, 28)));
            if ($urandom_range(0, 1) == 1) wait_neg(int'($urandom_range(1, 120)));
        end
        wait_neg(60);

        // Reset in the middle of a frame: immediate clear, no strobe.
        send_bits(8'hE7, 1'b0, 1'b1, 20, 0, 6, 1'b0, t);
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("midreset_dato", dato, 8'h00);
        chk("midreset_strobes", {dato_recibido, error_paridad, error_trama}, 3'b000);
        model_dato = 8'h00;
        wait_neg(3);
        reset  = 1'b1;
        mon_en = 1'b1;
        wait_neg(TO + 50);
        send_frame(8'h81, ~(^8'h81), 1'b1, 22);

        for (int w = 0; w < 2000 && sbq.size() != 0; w++) wait_neg(1);
        chk("scoreboard_drain", sbq.size(), 0);
        wait_neg(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_receptor.md
Name: ps2_receptor

Overview:
Upstream PS/2 receive stage for the mouse controller.
- Samples the bidirectional PS/2 clock/data lines, deglitches the PS/2 clock, and deserialises 11-bit device-to-host frames (start, 8 data LSB-first, odd parity, stop).
- Presents each byte with a one-cycle strobe, which the mouse controller consumes for the ACK (0xFA) and the three movement packets.
- Receive-only: never drives the lines.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required to change the filtered PS/2 clock level.
TIMEOUT, 5000, system clocks allowed between filtered falling edges inside a frame before abort (100 us at 50 MHz).

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
clkps2  input  1  PS/2 clock line as read from the inout pad.
dataps2  input  1  PS/2 data line as read from the inout pad.
rx_en  input  1  1 = reception allowed; 0 while the transmit stage owns the lines.
dato  output  8  last correctly received byte.
dato_recibido  output  1  one-cycle strobe: dato just updated.
error_paridad  output  1  one-cycle strobe: frame had bad parity, dato unchanged.
error_trama  output  1  one-cycle strobe: bad stop bit or timeout, dato unchanged.

Behaviour:
- Reset (reset=0, async): dato=0x00, all strobes 0, FSM=ESPERA, bit counter 0, timeout counter 0, filter shift register all ones, filtered clock=1, synchronisers=1.
- Synchronisation: both lines pass through a 2-flop synchroniser before any use.
- Clock filter: FILTER_LEN-bit shift register of the synchronised clkps2.
  - All ones -> filtered clock=1; all zeros -> 0; otherwise hold.
  - Edge detector registers the filtered clock; "flanco" is high for exactly one cycle on a 1->0 transition.
- Data is sampled only on flanco, using the synchronised dataps2 of that cycle.
- FSM states and transitions:
  - ESPERA: on flanco with rx_en=1 and data=0 -> DATOS, bit counter=0. Data=1 (false start) or rx_en=0 -> stay.
  - DATOS: on each flanco shift register <= {data, reg[7:1]} (LSB first), counter+1. After the 8th bit -> PARIDAD.
  - PARIDAD: on flanco store the parity bit -> PARADA.
  - PARADA: on flanco evaluate the stop bit, then -> ESPERA. Outcomes are checked in this priority:
    - stop=0 -> error_trama.
    - Parity bad -> error_paridad. Odd parity is correct when the XOR of 8 data bits and the parity bit is 1.
    - Otherwise dato <= shift register and dato_recibido=1.
- Strobe timing: strobes assert in the cycle after the flanco of the stop bit, last exactly one cycle, and are mutually exclusive. dato changes in the same cycle as dato_recibido and is stable until the next valid frame.
- Timeout: in any state except ESPERA, the counter increments each cycle without flanco and clears on flanco. Reaching TIMEOUT -> error_trama pulse, FSM=ESPERA, partial data discarded.
- rx_en falling to 0 in any state: FSM=ESPERA next cycle, counters cleared, no strobe.
- Reset mid-frame: immediate return to reset values, no strobe.
- Glitches on clkps2 shorter than FILTER_LEN cycles produce no flanco.
- Back-to-back frames: a start bit on the flanco following a PARADA is accepted; no dead time is required.

Test Plan:
1. Reset low with lines idle high, then release -> dato=0x00, no strobes for 1000 cycles.
2. Frame 0xFA, parity 1, stop 1, PS/2 bit period 40 clk -> dato_recibido one cycle, dato=0xFA, no error strobes.
3. Frame 0x08 with wrong parity 1 -> error_paridad one cycle, dato keeps 0xFA, dato_recibido stays 0.
4. Three back-to-back frames 0x09, 0x05, 0xFD with correct parity -> three dato_recibido pulses, dato sequence 0x09, 0x05, 0xFD.
5. Frame stopped after 4 data bits, TIMEOUT=200 -> error_trama exactly 200 cycles after the last flanco, FSM=ESPERA. A following frame 0x3C is received correctly.
6. 3-cycle low glitches on clkps2 while idle, then rx_en=0 during a valid frame 0x55 -> no flanco from the glitches, no strobes, dato unchanged.
